// File: rtl/canvas_arbiter.sv
// canvas_arbiter: 32x32 one-bit drawing canvas arbitrating mouse draws, a clear sweep and vblank snapshots.
// Optional macro DRAW_BRUSH_EN: a granted draw paints a 2x2 brush (clipped at the right/bottom edge).

module canvas_row #(
    parameter int GRID = 32
) (
    input  logic            clkVga,
    input  logic            iRstN,
    input  logic            clr,
    input  logic            wr_en,
    input  logic [GRID-1:0] wr_mask,
    input  logic            wr_val,
    output logic [GRID-1:0] row_q
);
    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN)
            row_q <= '0;
        else if (clr)
            row_q <= '0;
        else if (wr_en)
            row_q <= wr_val ? (row_q | wr_mask) : (row_q & ~wr_mask);
    end
endmodule

module canvas_arbiter #(
    parameter int GRID             = 32,
    parameter int ADDR_W           = 10,
    parameter int CLR_ROWS_PER_CYC = 1
) (
    input  logic                   clkVga,
    input  logic                   iRstN,
    input  logic                   iVblank,
    input  logic                   iDrawReq,
    input  logic [ADDR_W-1:0]      iDrawAddr,
    input  logic                   iDrawVal,
    output logic                   oDrawAck,
    input  logic                   iClearReq,
    output logic                   oClearBusy,
    input  logic                   iSnapReq,
    output logic                   oSnapValid,
    input  logic                   iSnapAck,
    output logic [GRID*GRID-1:0]   oSnapImage,
    output logic [GRID*GRID-1:0]   oCanvas
);
    localparam int ROW_W = ADDR_W / 2;
    localparam logic [ROW_W-1:0] CLR_STEP = ROW_W'(CLR_ROWS_PER_CYC);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GRID - CLR_ROWS_PER_CYC);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} snap_state_t;

    snap_state_t                snap_state;
    logic                       snap_pend;
    logic [ROW_W-1:0]           clr_row;
    logic                       clr_start;
    logic                       capture;
    logic [ROW_W-1:0]           draw_row;
    logic [ROW_W-1:0]           draw_col;
    logic [GRID-1:0]            cell_mask;
    logic [GRID-1:0]            col_mask;
    logic [GRID-1:0][GRID-1:0]  canvas_q;

    // Clear beats capture at the same edge; the capture then waits for the sweep to finish.
    assign clr_start = iClearReq & ~oClearBusy;
    assign capture   = (snap_state == S_WAIT) & iVblank & ~oClearBusy & ~clr_start;
    assign oDrawAck  = iDrawReq & ~oClearBusy & ~capture;

    assign draw_row  = iDrawAddr[ADDR_W-1 -: ROW_W];
    assign draw_col  = iDrawAddr[ROW_W-1:0];
    assign cell_mask = {{(GRID-1){1'b0}}, 1'b1} << draw_col;
`ifdef DRAW_BRUSH_EN
    // Left shift drops the col+1 cell past the right edge, so there is no wrap.
    assign col_mask  = cell_mask | (cell_mask << 1);
`else
    assign col_mask  = cell_mask;
`endif

    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            oClearBusy <= 1'b0;
            clr_row    <= '0;
        end else if (oClearBusy) begin
            if (clr_row == LAST_ROW) begin
                oClearBusy <= 1'b0;
                clr_row    <= '0;
            end else begin
                clr_row    <= clr_row + CLR_STEP;
            end
        end else if (iClearReq) begin
            oClearBusy <= 1'b1;
        end
    end

    for (genvar r = 0; r < GRID; r++) begin : g_row
        localparam logic [ROW_W-1:0] R = ROW_W'(r);
        logic clr_hit;
        logic wr_hit;

        // clr_row is always a multiple of the step, so an unsigned offset test covers the band.
        assign clr_hit = oClearBusy && ((R - clr_row) < CLR_STEP);
`ifdef DRAW_BRUSH_EN
        if (r > 0) begin : g_brush
            localparam logic [ROW_W-1:0] RB = ROW_W'(r - 1);
            assign wr_hit = oDrawAck && ((draw_row == R) || (draw_row == RB));
        end else begin : g_top
            assign wr_hit = oDrawAck && (draw_row == R);
        end
`else
        assign wr_hit = oDrawAck && (draw_row == R);
`endif

        canvas_row #(.GRID(GRID)) u_row (
            .clkVga  (clkVga),
            .iRstN   (iRstN),
            .clr     (clr_hit),
            .wr_en   (wr_hit),
            .wr_mask (col_mask),
            .wr_val  (iDrawVal),
            .row_q   (canvas_q[r])
        );
    end

    assign oCanvas = canvas_q;

    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            snap_state <= S_IDLE;
            snap_pend  <= 1'b0;
            oSnapValid <= 1'b0;
            oSnapImage <= '0;
        end else begin
            case (snap_state)
                S_IDLE: if (iSnapReq) snap_state <= S_WAIT;
                S_WAIT: if (capture) begin
                    oSnapImage <= oCanvas;
                    oSnapValid <= 1'b1;
                    snap_state <= S_HOLD;
                end
                S_HOLD: begin
                    if (iSnapAck) begin
                        oSnapValid <= 1'b0;
                        snap_pend  <= 1'b0;
                        snap_state <= (snap_pend | iSnapReq) ? S_WAIT : S_IDLE;
                    end else if (iSnapReq) begin
                        snap_pend  <= 1'b1;
                    end
                end
                default: snap_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/canvas_arbiter.md
Name: canvas_arbiter

Overview:
Owns the 32x32 one-bit drawing canvas and arbitrates every access to it. There are three clients: the mouse painter (pixel set/erase), a clear-all sweep sequencer, and the classifier snapshot port. Snapshots are frame-consistent and taken only during vertical blanking. The live canvas drives the VGA pixel path; the snapshot drives the DNN input.

Parameters:
GRID, 32, canvas side length in cells (fixed; address is {row[4:0], col[4:0]})
ADDR_W, 10, canvas cell address width
CLR_ROWS_PER_CYC, 1, rows zeroed per clear-sweep cycle (1 or 2; 32 must be divisible by it)

Ports:
clkVga  in  1  VGA pixel clock (40 MHz); all state on rising edge
iRstN  in  1  reset, asynchronous, active-low
iVblank  in  1  high during vertical blanking (synchronous to clkVga)
iDrawReq  in  1  draw request, level; address/value held stable while high
iDrawAddr  in  10  target cell {row, col}
iDrawVal  in  1  1 = set cell, 0 = erase cell
oDrawAck  out  1  combinational; high in the cycle the draw is written
iClearReq  in  1  single-cycle pulse; start clear sweep
oClearBusy  out  1  high while the sweep is running
iSnapReq  in  1  single-cycle pulse; request classifier snapshot
oSnapValid  out  1  snapshot register valid
iSnapAck  in  1  consumer done with snapshot
oSnapImage  out  1024  frozen snapshot copy
oCanvas  out  1024  live canvas (registered)

Behaviour:
- Reset (async, iRstN=0): oCanvas=0, oSnapImage=0, oSnapValid=0, oClearBusy=0, sweep row counter=0, snap FSM=S_IDLE, snap-pending=0.
- Clear sequencer:
  - iClearReq while idle: oClearBusy=1 next cycle.
  - Each busy cycle zeroes CLR_ROWS_PER_CYC rows, starting at row 0 and ascending.
  - oClearBusy falls the cycle after the last row is written: 32 busy cycles at default.
  - iClearReq while busy is ignored; the counter does not restart.
- Draw grant: oDrawAck = iDrawReq & ~oClearBusy & ~capture.
  - On grant, the canvas bit at iDrawAddr takes iDrawVal at that edge.
  - When not granted, the request waits (level held); nothing is dropped.
- Snapshot FSM:
  - S_IDLE: iSnapReq -> S_WAIT.
  - S_WAIT: capture fires when iVblank=1 and oClearBusy=0. On capture, oSnapImage<=oCanvas (pre-edge value) and oSnapValid<=1; then -> S_HOLD.
  - S_HOLD: oSnapImage is frozen. iSnapAck -> oSnapValid<=0 next cycle -> S_IDLE.
  - iSnapReq in S_WAIT is ignored. iSnapReq in S_HOLD sets snap-pending; on leaving S_HOLD, go directly to S_WAIT.
  - iSnapAck outside S_HOLD is ignored.
- Priority at the same edge is clear > capture > draw.
  - A capture cycle blocks the draw for one cycle (ack low), so the snapshot never contains a half-applied draw.
  - iClearReq arriving in S_WAIT: the capture is deferred until the sweep ends, so the snapshot is all-zero unless a draw has landed since.
  - iClearReq and iSnapReq in the same cycle: clear starts; snap enters S_WAIT and captures after the sweep.
- Draws are accepted in S_HOLD; they modify oCanvas only, never oSnapImage.
- Reset mid-sweep or mid-snapshot aborts immediately to reset values.

Optional Feature:
DRAW_BRUSH_EN
- Defined: a granted draw writes a 2x2 brush: (r,c), (r,c+1), (r+1,c), (r+1,c+1), all with iDrawVal, in a single cycle.
  - Cells past col 31 or row 31 are skipped, with no wrap to col 0 or row 0.
  - Grant and timing are unchanged.
- Undefined: single-cell write only.

Test Plan:
1. Reset, then iDrawReq addr=0x021 val=1 -> oDrawAck=1 same cycle; oCanvas[33]=1 next cycle; all other bits 0.
2. Set 5 cells, pulse iClearReq -> oClearBusy high for exactly 32 cycles. iDrawReq held during the sweep -> ack stays 0 until the busy cycle ends, then ack=1. Final canvas = that single draw.
3. Canvas with cells 0 and 1023 set, iSnapReq while iVblank=0 for 100 cycles -> oSnapValid stays 0. Raise iVblank -> oSnapValid=1 next cycle, oSnapImage bits 0 and 1023 = 1. Draw addr 5 afterwards -> oCanvas[5]=1, oSnapImage[5]=0. iSnapAck -> oSnapValid=0 next cycle.
4. iSnapReq and iClearReq in the same cycle with iVblank=1 -> capture after 32 sweep cycles; oSnapImage=0.
5. Drive iDrawReq continuously during the capture cycle -> oDrawAck=0 on the capture edge, 1 on the next edge. The snapshot excludes that cell.
6. DRAW_BRUSH_EN defined: draw addr {31,31} val=1 -> only bit 1023 set. Draw {0,30} -> bits 30, 31, 62, 63 set.
